// File: rtl/spi_frame_parser.sv
// SPI command frame parser: pulls bytes from the SPI slave FIFO and turns
// SYNC/ADDR/DATA_HI/DATA_LO/CHK frames into register write strobes.
// Optional frame statistics counters are built when SPI_FRAME_PARSER_STATS_EN is defined.

module spi_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] CHK_SEED       = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  fifo_data_in,
    input  logic        fifo_empty,
    output logic        fifo_read_en,
    output logic        reg_wr_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_err,
    output logic        busy,
    output logic        Debug_parser
`ifdef SPI_FRAME_PARSER_STATS_EN
    ,
    output logic [15:0] good_count,
    output logic [15:0] err_count
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_RD   = 2'd1;
    localparam logic [1:0] F_CAP  = 2'd2;

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DHI  = 3'd2;
    localparam logic [2:0] S_DLO  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    logic [1:0]    fetch_q;
    logic [1:0]    fetch_d;
    logic          byte_valid;
    logic [7:0]    rx_byte;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [7:0]    addr_q;
    logic [7:0]    hi_q;
    logic [7:0]    lo_q;
    logic [7:0]    exp_chk;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wr_d;
    logic          err_d;
    logic          timeout_hit;

    // A CAP cycle may chain straight into the next RD so a full FIFO
    // drains at one byte every two clocks without back-to-back pops.
    always_comb begin
        fetch_d = fetch_q;
        case (fetch_q)
            F_IDLE:  fetch_d = fifo_empty ? F_IDLE : F_RD;
            F_RD:    fetch_d = F_CAP;
            F_CAP:   fetch_d = fifo_empty ? F_IDLE : F_RD;
            default: fetch_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_q <= F_IDLE;
        end else begin
            fetch_q <= fetch_d;
        end
    end

    assign fifo_read_en = (fetch_q == F_RD);
    assign byte_valid   = (fetch_q == F_CAP);
    assign rx_byte      = fifo_data_in;

    assign exp_chk     = addr_q ^ hi_q ^ lo_q ^ CHK_SEED;
    assign timeout_hit = !byte_valid && (state_q != S_HUNT) && (cnt_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        err_d   = 1'b0;
        if (byte_valid) begin
            case (state_q)
                S_HUNT: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: state_d = S_DHI;
                S_DHI:  state_d = S_DLO;
                S_DLO:  state_d = S_CHK;
                S_CHK: begin
                    state_d = S_HUNT;
                    if (rx_byte == exp_chk) begin
                        wr_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end else if (timeout_hit) begin
            state_d = S_HUNT;
            err_d   = 1'b1;
        end
    end

    // The counter restarts at 1 on each accepted byte so that its value is
    // the number of cycles since that byte; the timeout is registered one
    // cycle before the limit and lands exactly TIMEOUT_CYCLES after CAP.
    always_comb begin
        if (state_d == S_HUNT) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d = CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_HUNT;
            cnt_q   <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (timeout_hit) begin
                addr_q <= '0;
                hi_q   <= '0;
                lo_q   <= '0;
            end else if (byte_valid) begin
                case (state_q)
                    S_ADDR:  addr_q <= rx_byte;
                    S_DHI:   hi_q   <= rx_byte;
                    S_DLO:   lo_q   <= rx_byte;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_wr_en    <= 1'b0;
            frame_err    <= 1'b0;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
            Debug_parser <= 1'b0;
        end else begin
            reg_wr_en <= wr_d;
            frame_err <= err_d;
            if (wr_d) begin
                reg_addr     <= addr_q;
                reg_wr_data  <= {hi_q, lo_q};
                Debug_parser <= ~Debug_parser;
            end
        end
    end

    assign busy = (state_q != S_HUNT);

`ifdef SPI_FRAME_PARSER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            good_count <= '0;
            err_count  <= '0;
        end else begin
            if (reg_wr_en && (good_count != 16'hFFFF)) begin
                good_count <= good_count + 16'd1;
            end
            if (frame_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule
